// File: rtl/memctrl_fifo.sv
// AVR memory/IO router: SRAM vs banked text-window routing, bank/cursor port
// registers, and a PS/2 scan-code FIFO with F0/E0 prefix tracking and SHIFT state.
module memctrl_fifo #(
  parameter logic [15:0] WIN_BASE  = 16'hF000,
  parameter logic [7:0]  TEXT_BANK = 8'h02,
  parameter int          KB_DEPTH  = 8,
  parameter int          KB_AW     = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        wren,
  input  logic        rden,
  input  logic [7:0]  data_o,
  output logic [7:0]  data_i,
  input  logic [7:0]  data_o_sram,
  input  logic [7:0]  data_o_text,
  output logic        data_w_sram,
  output logic        data_w_text,
  output logic [7:0]  bank,
  output logic [7:0]  cursor_x,
  output logic [7:0]  cursor_y,
  input  logic [7:0]  ps2_data,
  input  logic        ps2_hit,
  output logic        kb_irq
);

  localparam logic [15:0] PORT_BANK   = 16'h0020;
  localparam logic [15:0] PORT_KBD    = 16'h0021;
  localparam logic [15:0] PORT_STATUS = 16'h0022;
  localparam logic [15:0] PORT_FLAGS  = 16'h0023;
  localparam logic [15:0] PORT_CURX   = 16'h002C;
  localparam logic [15:0] PORT_CURY   = 16'h002D;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_LSHFT = 8'h12;
  localparam logic [7:0] PS2_RSHFT = 8'h59;

  localparam logic [KB_AW-1:0] PTR_ONE   = 1;
  localparam logic [KB_AW:0]   CNT_ONE   = 1;
  localparam logic [KB_AW:0]   CNT_DEPTH = (KB_AW+1)'(KB_DEPTH);

  // Control state
  logic [7:0]       bank_q, bank_d;
  logic [7:0]       cx_q, cx_d;
  logic [7:0]       cy_q, cy_d;
  logic [KB_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [KB_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [KB_AW:0]   cnt_q, cnt_d;
  logic             overflow_q, overflow_d;
  logic             up_pend_q, up_pend_d;
  logic             ext_pend_q, ext_pend_d;
  logic             shift_q, shift_d;
  logic             kb_irq_q;

  // Entry layout: {ext, up, scan code}
  logic [9:0] fifo_q [KB_DEPTH];

  logic       win, txt, port_wr;
  logic       empty, full;
  logic       flush, pop_ok, push_ok, is_code;
  logic [9:0] head;
  logic [4:0] cnt_w;
  logic [3:0] cnt_sat;
  logic [7:0] status;

  always_comb begin
    win     = (address >= WIN_BASE);
    txt     = (bank_q[7:1] == TEXT_BANK[7:1]);
    port_wr = wren && !win;
    empty   = (cnt_q == '0);
    full    = (cnt_q == CNT_DEPTH);
    head    = fifo_q[rd_ptr_q];
    cnt_w   = 5'(cnt_q);
    cnt_sat = (cnt_w > 5'd15) ? 4'hF : cnt_w[3:0];
    status  = {cnt_sat, shift_q, overflow_q, full, !empty};
  end

  // Routing and port read mux
  always_comb begin
    data_i      = data_o_sram;
    data_w_sram = wren;
    data_w_text = 1'b0;
    if (win) begin
      data_w_sram = 1'b0;
      if (txt) begin
        data_w_text = wren;
        data_i      = data_o_text;
      end else begin
        data_i = 8'hFF;
      end
    end else begin
      case (address)
        PORT_BANK:   data_i = bank_q;
        PORT_KBD:    data_i = empty ? 8'h00 : head[7:0];
        PORT_STATUS: data_i = status;
        PORT_FLAGS:  data_i = empty ? 8'h00 : {6'b0, head[9], head[8]};
        PORT_CURX:   data_i = cx_q;
        PORT_CURY:   data_i = cy_q;
        default:     data_i = data_o_sram;
      endcase
    end
  end

  // Next-state: port registers, prefix tracking, FIFO pointers
  always_comb begin
    bank_d     = bank_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    up_pend_d  = up_pend_q;
    ext_pend_d = ext_pend_q;
    shift_d    = shift_q;
    overflow_d = overflow_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;

    if (port_wr) begin
      case (address)
        PORT_BANK: bank_d = data_o;
        PORT_CURX: cx_d   = data_o;
        PORT_CURY: cy_d   = data_o;
        default:   ;
      endcase
    end

    flush   = port_wr && (address == PORT_STATUS) && data_o[7];
    is_code = ps2_hit && (ps2_data != PS2_BREAK) && (ps2_data != PS2_EXT);
    push_ok = is_code && !flush && !full;
    pop_ok  = rden && (address == PORT_KBD) && !empty && !flush;

    if (ps2_hit) begin
      if (ps2_data == PS2_BREAK) begin
        up_pend_d = 1'b1;
      end else if (ps2_data == PS2_EXT) begin
        ext_pend_d = 1'b1;
      end else begin
        up_pend_d  = 1'b0;
        ext_pend_d = 1'b0;
        if (ps2_data == PS2_LSHFT || ps2_data == PS2_RSHFT)
          shift_d = ~up_pend_q;
      end
    end

    if (flush) begin
      overflow_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
    end else begin
      if (is_code && full)
        overflow_d = 1'b1;
      if (push_ok)
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bank_q     <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      up_pend_q  <= 1'b0;
      ext_pend_q <= 1'b0;
      shift_q    <= 1'b0;
      kb_irq_q   <= 1'b0;
    end else begin
      bank_q     <= bank_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      up_pend_q  <= up_pend_d;
      ext_pend_q <= ext_pend_d;
      shift_q    <= shift_d;
      kb_irq_q   <= (cnt_d != '0);
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is valid
  always_ff @(posedge clock) begin
    if (push_ok)
      fifo_q[wr_ptr_q] <= {ext_pend_q, up_pend_q, ps2_data};
  end

  assign bank     = bank_q;
  assign cursor_x = cx_q;
  assign cursor_y = cy_q;
  assign kb_irq   = kb_irq_q;

endmodule

// File: tb/tb_memctrl_fifo.sv
// Bench for memctrl_fifo: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a queue-based behavioural model.
module tb_memctrl_fifo;

  localparam int KB_DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic        wren, rden;
  logic [7:0]  data_o, data_i, data_o_sram, data_o_text;
  logic        data_w_sram, data_w_text;
  logic [7:0]  bank, cursor_x, cursor_y;
  logic [7:0]  ps2_data;
  logic        ps2_hit;
  logic        kb_irq;

  memctrl_fifo #(
    .WIN_BASE(16'hF000), .TEXT_BANK(8'h02), .KB_DEPTH(KB_DEPTH), .KB_AW(3)
  ) dut (
    .clock(clock), .reset(reset), .address(address), .wren(wren), .rden(rden),
    .data_o(data_o), .data_i(data_i), .data_o_sram(data_o_sram),
    .data_o_text(data_o_text), .data_w_sram(data_w_sram),
    .data_w_text(data_w_text), .bank(bank), .cursor_x(cursor_x),
    .cursor_y(cursor_y), .ps2_data(ps2_data), .ps2_hit(ps2_hit), .kb_irq(kb_irq)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [9:0] mq[$];
  logic [7:0] m_bank, m_cx, m_cy;
  logic       m_shift, m_ovf, m_up, m_ext;
  logic       lw_s, lw_t;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] m_status();
    int n = mq.size();
    logic [3:0] c = (n > 15) ? 4'hF : 4'(n);
    return {c, m_shift, m_ovf, (n == KB_DEPTH), (n != 0)};
  endfunction

  function automatic logic [7:0] m_read(input logic [15:0] a, input logic [7:0] s, input logic [7:0] t);
    if (a >= 16'hF000) return (m_bank[7:1] == 7'h01) ? t : 8'hFF;
    case (a)
      16'h0020: return m_bank;
      16'h0021: return (mq.size() != 0) ? mq[0][7:0] : 8'h00;
      16'h0022: return m_status();
      16'h0023: return (mq.size() != 0) ? {6'b0, mq[0][9:8]} : 8'h00;
      16'h002C: return m_cx;
      16'h002D: return m_cy;
      default:  return s;
    endcase
  endfunction

  task automatic model_clear();
    mq.delete();
    m_bank = 0; m_cx = 0; m_cy = 0;
    m_shift = 0; m_ovf = 0; m_up = 0; m_ext = 0;
  endtask

  task automatic model_update(input logic [15:0] a, input logic we, input logic re,
                              input logic [7:0] wd, input logic hit, input logic [7:0] pb);
    logic flush, pop, push, win;
    logic [9:0] ent;
    win   = (a >= 16'hF000);
    flush = we && !win && a == 16'h0022 && wd[7];
    pop   = re && a == 16'h0021 && mq.size() != 0 && !flush;
    push  = 0;
    ent   = {m_ext, m_up, pb};
    if (hit) begin
      if (pb == 8'hF0) m_up = 1;
      else if (pb == 8'hE0) m_ext = 1;
      else begin
        if (pb == 8'h12 || pb == 8'h59) m_shift = ~m_up;
        if (!flush) begin
          if (mq.size() == KB_DEPTH) m_ovf = 1;
          else push = 1;
        end
        m_up = 0; m_ext = 0;
      end
    end
    if (flush) begin
      mq.delete(); m_ovf = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(ent);
    end
    if (we && !win) begin
      if (a == 16'h0020) m_bank = wd;
      if (a == 16'h002C) m_cx = wd;
      if (a == 16'h002D) m_cy = wd;
    end
  endtask

  task automatic step(input logic [15:0] a, input logic we, input logic re, input logic [7:0] wd,
                      input logic hit, input logic [7:0] pb, output logic [7:0] rd);
    logic win, txt;
    address = a; wren = we; rden = re; data_o = wd; ps2_hit = hit; ps2_data = pb;
    data_o_sram = 8'($urandom); data_o_text = 8'($urandom);
    #2;
    win = (a >= 16'hF000);
    txt = (m_bank[7:1] == 7'h01);
    check("data_i", {8'h0, data_i}, {8'h0, m_read(a, data_o_sram, data_o_text)});
    check("w_sram", {15'h0, data_w_sram}, {15'h0, we && !win});
    check("w_text", {15'h0, data_w_text}, {15'h0, we && win && txt});
    rd = data_i; lw_s = data_w_sram; lw_t = data_w_text;
    @(posedge clock);
    model_update(a, we, re, wd, hit, pb);
    #1;
    wren = 0; rden = 0; ps2_hit = 0;
    check("kb_irq", {15'h0, kb_irq}, {15'h0, mq.size() != 0});
    check("bank", {8'h0, bank}, {8'h0, m_bank});
    check("cur_xy", {cursor_x, cursor_y}, {m_cx, m_cy});
  endtask

  task automatic reset_dut();
    reset = 1; wren = 0; rden = 0; ps2_hit = 0;
    @(posedge clock); @(posedge clock);
    #1 reset = 0;
    model_clear();
  endtask

  logic [7:0] rd;
  task automatic rdp(input logic [15:0] a);  step(a, 0, 1, 8'h00, 0, 8'h00, rd); endtask
  task automatic wrp(input logic [15:0] a, input logic [7:0] d);  step(a, 1, 0, d, 0, 8'h00, rd); endtask
  task automatic inj(input logic [7:0] b);  step(16'h0100, 0, 0, 8'h00, 1, b, rd); endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb, rw;
    reset = 1; address = 0; wren = 0; rden = 0; data_o = 0;
    data_o_sram = 0; data_o_text = 0; ps2_data = 0; ps2_hit = 0;
    model_clear();
    reset_dut();

    // Reset state
    rdp(16'h0020); check("rst_bank", {8'h0, rd}, 16'h0000);
    rdp(16'h002C); check("rst_cx", {8'h0, rd}, 16'h0000);
    rdp(16'h002D); check("rst_cy", {8'h0, rd}, 16'h0000);
    rdp(16'h0021); check("rst_kbd", {8'h0, rd}, 16'h0000);
    rdp(16'h0022); check("rst_stat", {8'h0, rd}, 16'h0000);
    check("rst_irq", {15'h0, kb_irq}, 16'h0000);

    // Window routing
    wrp(16'h0020, 8'h03);
    wrp(16'hF010, 8'h41);
    check("win_txt_wt", {14'h0, lw_t, lw_s}, 16'h0002);
    wrp(16'h0020, 8'h05);
    rdp(16'hF010);
    check("win_off_rd", {8'h0, rd}, 16'h00FF);
    check("win_off_we", {14'h0, lw_t, lw_s}, 16'h0000);
    wrp(16'h0100, 8'h77);
    check("sram_we", {14'h0, lw_t, lw_s}, 16'h0001);

    // Prefixes and pop order
    inj(8'hE0); inj(8'hF0); inj(8'h75); inj(8'h1C);
    rdp(16'h0022); check("stat_2", {8'h0, rd}, 16'h0021);
    rdp(16'h0023); check("flags_ext_up", {8'h0, rd}, 16'h0003);
    rdp(16'h0021); check("pop_75", {8'h0, rd}, 16'h0075);
    rdp(16'h0023); check("flags_plain", {8'h0, rd}, 16'h0000);
    rdp(16'h0021); check("pop_1c", {8'h0, rd}, 16'h001C);
    check("irq_drop", {15'h0, kb_irq}, 16'h0000);
    rdp(16'h0022); check("stat_empty", {8'h0, rd}, 16'h0000);

    // SHIFT tracking
    inj(8'h12);
    rdp(16'h0022); check("shift_on", {8'h0, rd & 8'h08}, 16'h0008);
    inj(8'hF0); inj(8'h12);
    rdp(16'h0022); check("shift_off", {8'h0, rd}, 16'h0021);
    rdp(16'h0021); check("sh_pop1", {8'h0, rd}, 16'h0012);
    rdp(16'h0023); check("sh_up2", {8'h0, rd}, 16'h0001);
    wrp(16'h0022, 8'h80);

    // Overflow and flush
    for (int i = 0; i <= KB_DEPTH; i++) inj(8'h30 + 8'(i));
    rdp(16'h0022); check("stat_full", {8'h0, rd}, 16'h0087);
    for (int i = 0; i < KB_DEPTH; i++) begin
      rdp(16'h0021); check("ovf_order", {8'h0, rd}, {8'h0, 8'h30 + 8'(i)});
    end
    rdp(16'h0022); check("ovf_sticky", {8'h0, rd}, 16'h0004);
    wrp(16'h0022, 8'h80);
    rdp(16'h0022); check("flushed", {8'h0, rd}, 16'h0000);

    // Simultaneous push/pop across pointer wrap
    inj(8'h40); inj(8'h41); inj(8'h42);
    for (int i = 0; i < 10; i++) begin
      step(16'h0021, 0, 1, 8'h00, 1, 8'h43 + 8'(i), rd);
      check("pp_order", {8'h0, rd}, {8'h0, 8'h40 + 8'(i)});
    end
    rdp(16'h0022); check("pp_cnt", {8'h0, rd}, 16'h0031);
    for (int i = 0; i < 3; i++) begin
      rdp(16'h0021); check("pp_drain", {8'h0, rd}, {8'h0, 8'h4A + 8'(i)});
    end

    // Reset drops a pending prefix
    inj(8'hF0);
    reset_dut();
    inj(8'h1C);
    rdp(16'h0023); check("rst_pend", {8'h0, rd}, 16'h0000);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 399) == 0) reset_dut();
      case ($urandom_range(0, 9))
        0, 1:    ra = 16'h0021;
        2:       ra = ($urandom_range(0, 3) == 0) ? 16'h0022 : 16'h0023;
        3:       ra = 16'h0020;
        4:       ra = 16'h002C + 16'($urandom_range(0, 1));
        5, 6:    ra = 16'hF000 + 16'($urandom_range(0, 16'h0FFF));
        default: ra = 16'($urandom_range(0, 16'hEFFF));
      endcase
      case ($urandom_range(0, 6))
        0: rb = 8'hF0;
        1: rb = 8'hE0;
        2: rb = 8'h12;
        3: rb = 8'h59;
        default: rb = 8'($urandom);
      endcase
      rw = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(2, 3)) : 8'($urandom);
      step(ra, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, rw,
           $urandom_range(0, 4) < 2, rb, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
